// File: rtl/uart_burst_buffer_if.sv
// Byte-stream bundle between uart_rx, the burst buffer and uart_tx.
// Ports: rx_done/rx_data (receive strobe and byte), tx_busy (uart_tx status),
//        tx_en/tx_data (send strobe and byte), level, overflow, drop_cnt (UART_BUF_DROP_CNT_EN).
// Modports: slave = buffer side, master = the uart_rx/uart_tx side that drives the buffer.
interface uart_burst_buffer_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8
);
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              tx_busy;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic [DEPTH_LOG2:0] level;
    logic              overflow;
`ifdef UART_BUF_DROP_CNT_EN
    logic [15:0]       drop_cnt;

    modport slave  (input rx_done, rx_data, tx_busy,
                    output tx_en, tx_data, level, overflow, drop_cnt);
    modport master (output rx_done, rx_data, tx_busy,
                    input tx_en, tx_data, level, overflow, drop_cnt);
`else
    modport slave  (input rx_done, rx_data, tx_busy,
                    output tx_en, tx_data, level, overflow);
    modport master (output rx_done, rx_data, tx_busy,
                    input tx_en, tx_data, level, overflow);
`endif
endinterface

// File: rtl/uart_burst_buffer.sv
// Store-and-forward FIFO between uart_rx and uart_tx; drains on RX-idle timeout or burst level.
// Latency: first tx_en 3 clocks after the drain trigger; then one byte per tx_busy cycle + 4 clocks.
// Backpressure: tx_busy holds draining; rx_done is never stalled, a write while full is dropped (overflow).
// Ports: clk, rst (async active-high), bus (uart_burst_buffer_if.slave).
// Optional macro UART_BUF_DROP_CNT_EN adds a saturating 16-bit dropped-byte counter (bus.drop_cnt).
module uart_burst_buffer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int TIMEOUT    = 50000,
    parameter int CNT_W      = 16,
    parameter int BURST_TH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    uart_burst_buffer_if.slave  bus
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]    TMAX       = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    TMR_ONE    = CNT_W'(1);
    localparam logic [31:0]         BURST_TH_W = 32'(BURST_TH);

    typedef enum logic [2:0] {COLLECT, DRAIN, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic [CNT_W-1:0]      timer;
    logic [1:0]            wait_cnt;
    logic                  tx_en_q, overflow_q;
    logic [DATA_W-1:0]     tx_data_q;
    logic                  full, wr, rd, timeout_hit, burst_hit;

    assign full        = (level_q == FULL_LVL);
    assign wr          = bus.rx_done && !full;
    // Exactly one read per ISSUE; DRAIN only enters ISSUE with level != 0.
    assign rd          = (state == ISSUE);
    // A byte arriving on the expiry clock restarts the idle window instead.
    assign timeout_hit = (timer == TMAX) && !bus.rx_done;
    assign burst_hit   = (BURST_TH != 0) && (32'(level_q) >= BURST_TH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT:   if (timeout_hit || burst_hit) state_nxt = DRAIN;
            DRAIN:     if (level_q == '0)            state_nxt = COLLECT;
                       else if (!bus.tx_busy)        state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            // Give up on busy after 4 quiet clocks so a missed busy cannot hang the drain.
            WAIT_BUSY: if (bus.tx_busy)              state_nxt = WAIT_DONE;
                       else if (wait_cnt == 2'd3)    state_nxt = DRAIN;
            WAIT_DONE: if (!bus.tx_busy)             state_nxt = DRAIN;
            default:   state_nxt = COLLECT;
        endcase
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            timer      <= '0;
            wait_cnt   <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.rx_done && full;
            tx_en_q    <= rd;
            if (wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                tx_data_q <= mem[rd_ptr];
            end
            case ({wr, rd})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            // Idle timer only runs while collecting a non-empty FIFO.
            if (bus.rx_done)                            timer <= '0;
            else if (level_q == '0)                     timer <= '0;
            else if (state == COLLECT && timer != TMAX) timer <= timer + TMR_ONE;
            if (state == WAIT_BUSY && !bus.tx_busy) wait_cnt <= wait_cnt + 2'd1;
            else                                    wait_cnt <= '0;
        end
    end

    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

`ifdef UART_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     drop_cnt_q <= '0;
        else if (overflow_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_burst_buffer.sv
// Directed bench for uart_burst_buffer (DEPTH_LOG2=4, TIMEOUT=100, BURST_TH=8).
// A simple uart_tx model raises tx_busy for 10 clocks starting the clock after tx_en.
// Ports exercised through uart_burst_buffer_if; drop_cnt checks only with UART_BUF_DROP_CNT_EN.
module tb_uart_burst_buffer;
    localparam int BT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   ovf_cnt = 0;
    int   busy_viol = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] got[$];
    int         tx_cyc[$];

    uart_burst_buffer_if #(.DATA_W(8), .DEPTH_LOG2(4)) bif ();

    uart_burst_buffer #(
        .DATA_W(8), .DEPTH_LOG2(4), .TIMEOUT(100), .CNT_W(16), .BURST_TH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    assign bif.tx_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.tx_en)         busy_cnt <= BT;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (bif.tx_en) begin
            got.push_back(bif.tx_data);
            tx_cyc.push_back(cyc);
            if (bif.tx_busy) busy_viol++;
        end
        if (bif.overflow) ovf_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        bif.rx_done = 1'b1;
        bif.rx_data = b;
        c = cyc;
        @(posedge clk); #1;
        bif.rx_done = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_q();
        got.delete();
        tx_cyc.delete();
    endtask

    task automatic test_reset();
        bif.rx_done = 1'b0;
        bif.rx_data = '0;
        rst = 1'b1;
        tick(3);
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", bif.level); end
        checks++; if (bif.tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got=%b want=0", bif.tx_en); end
        checks++; if (bif.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", bif.tx_data); end
        checks++; if (bif.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", bif.overflow); end
`ifdef UART_BUF_DROP_CNT_EN
        checks++; if (bif.drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got=%h want=0000", bif.drop_cnt); end
`endif
        rst = 1'b0;
        tick(5);
        checks++; if (bif.level !== 5'd0 || bif.tx_en !== 1'b0) begin errors++; $display("FAIL post_reset_idle level=%0d tx_en=%b want 0/0", bif.level, bif.tx_en); end
    endtask

    task automatic test_timeout();
        int c;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        clear_q();
        send_byte(8'h11, c); tick(19);
        send_byte(8'h22, c); tick(19);
        send_byte(8'h33, c);
        wait_bytes(3, 400);
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL timeout_count got=%0d want=3", got.size());
        end else begin
            checks++; if (tx_cyc[0] != c + 103) begin errors++; $display("FAIL timeout_first_tx_cycle got=%0d want=%0d", tx_cyc[0], c + 103); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL timeout_byte%0d got=%h want=%h", i, got[i], exp[i]); end
            end
            checks++; if (tx_cyc[1] - tx_cyc[0] != 14) begin errors++; $display("FAIL timeout_spacing01 got=%0d want=14", tx_cyc[1] - tx_cyc[0]); end
            checks++; if (tx_cyc[2] - tx_cyc[1] != 14) begin errors++; $display("FAIL timeout_spacing12 got=%0d want=14", tx_cyc[2] - tx_cyc[1]); end
        end
        tick(20);
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL timeout_end_level got=%0d want=0", bif.level); end
    endtask

    task automatic test_burst();
        int c;
        clear_q();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'hA0 + i), c);
            if (i < 7) tick(9);
        end
        wait_bytes(8, 400);
        checks++;
        if (got.size() != 8) begin
            errors++; $display("FAIL burst_count got=%0d want=8", got.size());
        end else begin
            checks++; if (tx_cyc[0] != c + 4) begin errors++; $display("FAIL burst_first_tx_cycle got=%0d want=%0d", tx_cyc[0], c + 4); end
            for (int i = 0; i < 8; i++) begin
                checks++; if (got[i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL burst_byte%0d got=%h want=%h", i, got[i], 8'(8'hA0 + i)); end
            end
        end
        tick(20);
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL burst_end_level got=%0d want=0", bif.level); end
    endtask

    task automatic test_overflow();
        int ovf0;
        clear_q();
        ovf0 = ovf_cnt;
        force_busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bif.rx_done = 1'b1;
            bif.rx_data = 8'(8'h40 + i);
            @(posedge clk); #1;
        end
        bif.rx_done = 1'b0;
        checks++; if (bif.level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d want=16", bif.level); end
        tick(3);
        checks++; if (ovf_cnt - ovf0 != 2) begin errors++; $display("FAIL ovf_pulses got=%0d want=2", ovf_cnt - ovf0); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL ovf_tx_while_busy got=%0d want=0", got.size()); end
`ifdef UART_BUF_DROP_CNT_EN
        checks++; if (bif.drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got=%0d want=2", bif.drop_cnt); end
`endif
        force_busy = 1'b0;
        wait_bytes(16, 500);
        checks++;
        if (got.size() != 16) begin
            errors++; $display("FAIL ovf_drain_count got=%0d want=16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (got[i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL ovf_byte%0d got=%h want=%h", i, got[i], 8'(8'h40 + i)); end
            end
        end
        tick(20);
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL ovf_end_level got=%0d want=0", bif.level); end
    endtask

    task automatic test_issue_collide();
        int c, c2;
        logic [7:0] exp [3];
        exp[0] = 8'h51; exp[1] = 8'h52; exp[2] = 8'h53;
        clear_q();
        send_byte(8'h51, c);
        send_byte(8'h52, c);
        // First ISSUE lands 102 clocks after the last rx_done.
        while (cyc < c + 102) begin @(posedge clk); #1; end
        checks++; if (bif.level !== 5'd2) begin errors++; $display("FAIL collide_pre_level got=%0d want=2", bif.level); end
        send_byte(8'h53, c2);
        checks++; if (bif.level !== 5'd2) begin errors++; $display("FAIL collide_level got=%0d want=2", bif.level); end
        wait_bytes(3, 300);
        tick(60);
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL collide_count got=%0d want=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL collide_byte%0d got=%h want=%h", i, got[i], exp[i]); end
            end
        end
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL collide_end_level got=%0d want=0", bif.level); end
    endtask

    task automatic test_reset_mid_drain();
        int c;
        clear_q();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), c);
        wait_bytes(1, 200);
        tick(4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL rstmid_level got=%0d want=0", bif.level); end
        checks++; if (bif.tx_en !== 1'b0 || bif.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_pulses tx_en=%b overflow=%b want 0/0", bif.tx_en, bif.overflow); end
        checks++; if (bif.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got=%h want=00", bif.tx_data); end
        tick(150);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rstmid_no_tx got=%0d want=1", got.size()); end
        send_byte(8'h71, c);
        send_byte(8'h72, c);
        wait_bytes(3, 300);
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL rstmid_burst_count got=%0d want=3", got.size());
        end else begin
            checks++; if (got[1] !== 8'h71 || got[2] !== 8'h72) begin errors++; $display("FAIL rstmid_burst_bytes got=%h,%h want=71,72", got[1], got[2]); end
            checks++; if (tx_cyc[1] != c + 103) begin errors++; $display("FAIL rstmid_burst_cycle got=%0d want=%0d", tx_cyc[1], c + 103); end
        end
        tick(20);
        checks++; if (bif.level !== 5'd0) begin errors++; $display("FAIL rstmid_end_level got=%0d want=0", bif.level); end
    endtask

`ifdef UART_BUF_DROP_CNT_EN
    task automatic test_drop_sat();
        int ovf0;
        checks++; if (bif.drop_cnt !== 16'h0) begin errors++; $display("FAIL dropsat_start got=%h want=0000", bif.drop_cnt); end
        ovf0 = ovf_cnt;
        force_busy = 1'b1;
        bif.rx_done = 1'b1;
        bif.rx_data = 8'h99;
        repeat (16 + 70000) @(posedge clk);
        #1;
        bif.rx_done = 1'b0;
        tick(3);
        checks++; if (ovf_cnt - ovf0 != 70000) begin errors++; $display("FAIL dropsat_pulses got=%0d want=70000", ovf_cnt - ovf0); end
        checks++; if (bif.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL dropsat_value got=%h want=ffff", bif.drop_cnt); end
        force_busy = 1'b0;
    endtask
`endif

    initial begin
        bif.rx_done = 1'b0;
        bif.rx_data = '0;
        test_reset();
        test_timeout();
        test_burst();
        test_overflow();
        test_issue_collide();
        test_reset_mid_drain();
`ifdef UART_BUF_DROP_CNT_EN
        test_drop_sat();
`endif
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL tx_en_while_busy got=%0d want=0", busy_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
